dot_stream_mac: RTL and testbench
=================================

# dot_stream_mac

Streaming half-precision (IEEE 754 binary16) dot-product engine, the parametrised successor to the fixed 12-pair unrolled MAC. One multiplier `fpu` (opcode 1) and one adder `fpu` (opcode 0) are reused across a run-time vector length of up to `MAX_LEN` element pairs. Operands arrive over a valid/ready stream and the result leaves over a valid/ready result port. A `keep` mode continues accumulation across consecutive vectors.

## Interface
- `MAX_LEN`, 16: maximum pairs per vector. `LEN_W = $clog2(MAX_LEN+1)` is derived.
- `FPU_LAT`, 1: cycles from operands held stable at an `fpu` input to a valid registered `O`. Must be ≥1.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a vector. Sampled only in IDLE.
- `len` in `LEN_W`: pair count, latched on start. Values above `MAX_LEN` are clamped to `MAX_LEN`.
- `keep` in 1: latched on start. 0 clears the accumulator to +0 (16'h0000). 1 continues from the current accumulator.
- `busy` out 1: high in every state except IDLE.
- `in_valid` in 1 / `in_ready` out 1: operand handshake.
- `a`, `b` in 16: binary16 operand pair, consumed when `in_valid & in_ready`.
- `out_valid` out 1 / `out_ready` in 1: result handshake.
- `dot_product` out 16: accumulator, registered.

## Operation
- The FSM has five states: IDLE, FETCH, MUL, ADD, DONE.
- **IDLE**
  - `in_ready`=0 and `out_valid`=0.
  - On `start`: latch the clamped `len` into `len_q`, clear `cnt`, and clear `acc` if `keep`=0.
  - Go to FETCH if `len_q`≠0, otherwise go to DONE.
- **FETCH**
  - `in_ready`=1.
  - On handshake: register `a`/`b` into the multiplier operand registers, load the wait counter with `FPU_LAT`, and go to MUL.
  - Without a handshake, stay in FETCH indefinitely.
- **MUL**
  - The multiplier operands are held stable.
  - After `FPU_LAT` cycles, register the product into the adder B operand, with `acc` on adder A, reload the wait counter, and go to ADD.
- **ADD**
  - The adder operands are held stable.
  - After `FPU_LAT` cycles: `acc` ← sum and `cnt` ← `cnt`+1.
  - Go to DONE if the new `cnt` equals `len_q`, otherwise go to FETCH.
- **DONE**
  - `out_valid`=1.
  - Go to IDLE on `out_ready`.
- **Accumulator behaviour**
  - `dot_product` always reflects `acc` and is stable for the whole of DONE.
  - `acc` is retained after IDLE so a later `keep`=1 start continues from it.
- **Handshake rules**
  - `start` in any state other than IDLE is ignored; it is not queued.
  - `in_valid` outside FETCH is ignored.
  - `in_ready` is asserted only in FETCH, so at most one pair is in flight.
- **Arithmetic**
  - All arithmetic is binary16, performed by the two `fpu` instances.
  - There is no rounding, flag or exception logic in this block. NaN and Inf propagate as the `fpu` produces them.
  - The accumulation order is strictly sequential, element 0 first, matching the unrolled chain.

## Timing
- **Per-pair occupancy:** 1 (FETCH handshake) + `FPU_LAT` (MUL) + `FPU_LAT` (ADD) = 2·`FPU_LAT`+1 cycles, with `in_valid` held high.
- **Start-to-result latency:** with `start` sampled at edge t and no input stalls, `out_valid` rises in the cycle after edge t + `len_q`·(2·`FPU_LAT`+1).
  - Example, `FPU_LAT`=1 and `len`=3: `out_valid` is high in cycle t+10, i.e. 9 edges after the start edge.
  - `len`=0: `out_valid` is high in the cycle immediately after the start edge.
- **Back-to-back vectors:** the minimum IDLE dwell between vectors is 1 cycle (DONE → IDLE → start).
- **Reset:** `rst` high at an edge forces the following values next cycle, aborting any operation in progress and discarding in-flight products:
  - state=IDLE;
  - `acc`=16'h0000 and `dot_product`=16'h0000;
  - `cnt`=0, `len_q`=0;
  - `busy`=0, `in_ready`=0, `out_valid`=0.
- **Reset vs. start:** `rst` has priority over a simultaneous `start`.

## Test plan
1. **Basic vector.** `FPU_LAT`=1, `keep`=0, `len`=3, pairs (3C00,4000), (4200,4400), (3800,4400), i.e. 1·2+3·4+0.5·4.
   - `dot_product`=16'h4C00 (16.0).
   - `out_valid` high exactly 9 edges after the start edge.
2. **Keep mode.** Immediately after test 1: `keep`=1, `len`=1, pair (4000,4200).
   - `dot_product`=16'h4D80 (22.0).
3. **Zero length.** `keep`=0, `len`=0.
   - `out_valid` high the cycle after start, with `dot_product`=16'h0000.
   - `in_ready` never asserts.
4. **Backpressure.**
   - Apply 3-cycle `in_valid` gaps between pairs of test 1, hold `out_ready` low 5 cycles in DONE, and pulse `start` while `busy`.
   - Result is still 16'h4C00, stable throughout DONE.
   - The `start` pulse has no effect.
5. **Reset mid-operation.** `rst` after 2 of 4 pairs (1,1).
   - Next cycle all outputs are zero and the state is IDLE.
   - A new `keep`=1, `len`=1 run with (3C00,3C00) yields 16'h3C00, so no stale sum remains.
6. **Length clamp.** `MAX_LEN`=16, `len`=20, pairs (3C00,3C00) supplied continuously.
   - Exactly 16 handshakes occur.
   - `dot_product`=16'h4C00.

Source files
------------

// File: rtl/dot_stream_mac.sv
// Streaming binary16 dot-product engine: one multiplier and one adder fpu are
// reused sequentially over up to MAX_LEN operand pairs per vector.

module fpu #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] o
);

  localparam logic [15:0] QNAN = 16'h7E00;

  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
  endfunction

  function automatic logic is_inf(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] == 10'h000);
  endfunction

  // Subnormal inputs are flushed to zero.
  function automatic logic is_zero(input logic [15:0] x);
    return x[14:10] == 5'h00;
  endfunction

  function automatic logic [15:0] fp16_pack(input logic s, input int e_in,
                                            input logic [11:0] m_in,
                                            input logic g, input logic st);
    logic [11:0] m;
    int          e;
    m = m_in;
    e = e_in;
    if (g && (st || m[0])) m = m + 12'd1;
    if (m[11]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 31) return {s, 5'h1F, 10'h000};
    if (e <= 0) return {s, 15'h0000};
    return {s, e[4:0], m[9:0]};
  endfunction

  function automatic logic [15:0] fp16_mul(input logic [15:0] x, input logic [15:0] y);
    logic        s;
    logic [21:0] p;
    int          e;
    s = x[15] ^ y[15];
    if (is_nan(x) || is_nan(y) || (is_inf(x) && is_zero(y)) || (is_zero(x) && is_inf(y)))
      return QNAN;
    if (is_inf(x) || is_inf(y)) return {s, 5'h1F, 10'h000};
    if (is_zero(x) || is_zero(y)) return {s, 15'h0000};
    p = {1'b1, x[9:0]} * {1'b1, y[9:0]};
    e = int'(x[14:10]) + int'(y[14:10]) - 15;
    if (p[21]) return fp16_pack(s, e + 1, {1'b0, p[21:11]}, p[10], |p[9:0]);
    return fp16_pack(s, e, {1'b0, p[20:10]}, p[9], |p[8:0]);
  endfunction

  function automatic logic [15:0] fp16_add(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] big;
    logic [15:0] sml;
    logic [13:0] mb;
    logic [13:0] ms;
    logic [27:0] sh;
    logic [14:0] n;
    int          d;
    int          e;
    if (is_nan(x) || is_nan(y)) return QNAN;
    if (is_inf(x) && is_inf(y) && (x[15] != y[15])) return QNAN;
    if (is_inf(x)) return x;
    if (is_inf(y)) return y;
    if (is_zero(x) && is_zero(y)) return {x[15] & y[15], 15'h0000};
    if (is_zero(x)) return y;
    if (is_zero(y)) return x;
    if (x[14:0] >= y[14:0]) begin
      big = x;
      sml = y;
    end else begin
      big = y;
      sml = x;
    end
    d = int'(big[14:10]) - int'(sml[14:10]);
    if (d > 15) d = 15;
    // Three guard bits below the mantissa, with shifted-out bits folded into a sticky LSB.
    mb = {1'b1, big[9:0], 3'b000};
    sh = {1'b1, sml[9:0], 3'b000, 14'h0000} >> d;
    ms = sh[27:14] | {13'h0000, |sh[13:0]};
    e  = int'(big[14:10]);
    if (big[15] == sml[15]) n = {1'b0, mb} + {1'b0, ms};
    else                    n = {1'b0, mb} - {1'b0, ms};
    if (n == 15'h0000) return 16'h0000;
    if (n[14]) begin
      n = {1'b0, n[14:1]} | {14'h0000, n[0]};
      e = e + 1;
    end
    for (int i = 0; i < 13; i++) begin
      if (!n[13]) begin
        n = n << 1;
        e = e - 1;
      end
    end
    return fp16_pack(big[15], e, {1'b0, n[13:3]}, n[2], |n[1:0]);
  endfunction

  logic [15:0] res;
  assign res = op ? fp16_mul(a, b) : fp16_add(a, b);

  // The consumer's capture register is the last of the LAT stages, so only LAT-1 live here.
  generate
    if (LAT == 1) begin : g_comb
      assign o = res;
    end else begin : g_pipe
      logic [15:0] pipe_q [LAT-1];
      logic [15:0] pipe_d [LAT-1];
      always_comb begin
        pipe_d[0] = res;
        for (int i = 1; i < LAT - 1; i++) pipe_d[i] = pipe_q[i-1];
      end
      always_ff @(posedge clk) pipe_q <= pipe_d;
      assign o = pipe_q[LAT-2];
    end
  endgenerate

endmodule

module dot_stream_mac #(
  parameter int  MAX_LEN = 16,
  parameter int  FPU_LAT = 1,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             keep,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      dot_product
);

  localparam int WAIT_W = $clog2(FPU_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MUL, S_ADD, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d, len_clamped;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [15:0]       acc_q, acc_d, mul_a_q, mul_a_d, mul_b_q, mul_b_d, add_b_q, add_b_d;
  logic [15:0]       mul_o, add_o;

  assign len_clamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;

  fpu #(.LAT(FPU_LAT)) u_mul (.clk(clk), .op(1'b1), .a(mul_a_q), .b(mul_b_q), .o(mul_o));
  fpu #(.LAT(FPU_LAT)) u_add (.clk(clk), .op(1'b0), .a(acc_q),   .b(add_b_q), .o(add_o));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    acc_d   = acc_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    add_b_d = add_b_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d = len_clamped;
          cnt_d = '0;
          if (!keep) acc_d = 16'h0000;
          state_d = (len_clamped != '0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: begin
        if (in_valid) begin
          mul_a_d = a;
          mul_b_d = b;
          wait_d  = WAIT_W'(FPU_LAT);
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (wait_q == WAIT_W'(1)) begin
          add_b_d = mul_o;
          wait_d  = WAIT_W'(FPU_LAT);
          state_d = S_ADD;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      S_ADD: begin
        if (wait_q == WAIT_W'(1)) begin
          acc_d   = add_o;
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_d == len_q) ? S_DONE : S_FETCH;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      acc_q   <= 16'h0000;
      mul_a_q <= 16'h0000;
      mul_b_q <= 16'h0000;
      add_b_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      acc_q   <= acc_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      add_b_q <= add_b_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign in_ready    = (state_q == S_FETCH);
  assign out_valid   = (state_q == S_DONE);
  assign dot_product = acc_q;

endmodule

// File: tb/tb_dot_stream_mac.sv
// Self-checking bench for dot_stream_mac: table of vectors with hand-computed
// binary16 results, scoreboard queue, plus backpressure, reset and clamp sequences.

module tb_dot_stream_mac;

  localparam int MAX_LEN = 16;
  localparam int FPU_LAT = 1;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             keep;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      a;
  logic [15:0]      b;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      dot_product;

  dot_stream_mac #(.MAX_LEN(MAX_LEN), .FPU_LAT(FPU_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .keep(keep), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .dot_product(dot_product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            keep;
    int              len;
    logic [3:0][15:0] pa;
    logic [3:0][15:0] pb;
    logic [15:0]     exp_dot;
  } vec_t;

  typedef struct {
    logic [15:0] dot;
    int          lat;
    int          hs;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic k, input int n,
                              input logic [15:0] a0, input logic [15:0] b0,
                              input logic [15:0] a1, input logic [15:0] b1,
                              input logic [15:0] a2, input logic [15:0] b2,
                              input logic [15:0] ex);
    vec_t v;
    v.keep    = k;
    v.len     = n;
    v.pa      = {16'h0000, a2, a1, a0};
    v.pb      = {16'h0000, b2, b1, b0};
    v.exp_dot = ex;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one vector: drives start and operand pairs, then pops the scoreboard when out_valid appears.
  task automatic applyStimulus(input vec_t v, input int gap, input int hold, input bit poke);
    exp_t e;
    int   len_eff, idx, hs, gap_cnt, lat, ready_cyc;
    bit   prev_hs, got;
    len_eff = (v.len > MAX_LEN) ? MAX_LEN : v.len;
    e.dot   = v.exp_dot;
    e.lat   = len_eff * (2 * FPU_LAT + 1);
    e.hs    = len_eff;
    sb_q.push_back(e);
    start    = 1'b1;
    keep     = v.keep;
    len      = LEN_W'(v.len);
    in_valid = (v.len > 0);
    a        = v.pa[0];
    b        = v.pb[0];
    idx = 0; hs = 0; gap_cnt = 0; lat = 0; ready_cyc = 0;
    prev_hs = 1'b0; got = 1'b0;
    @(negedge clk);
    start = 1'b0;
    keep  = 1'b0;
    len   = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (prev_hs) begin
        hs++;
        idx++;
        gap_cnt = gap;
      end else if (gap_cnt > 0) begin
        gap_cnt--;
      end
      if (out_valid) begin
        got      = 1'b1;
        lat      = cyc;
        in_valid = 1'b0;
        start    = 1'b0;
        break;
      end
      in_valid = (idx < v.len) && (gap_cnt == 0);
      a        = v.pa[idx % 4];
      b        = v.pb[idx % 4];
      if (in_ready) ready_cyc++;
      prev_hs = in_ready && in_valid;
      if (poke && cyc == 4) begin
        start = 1'b1;
        keep  = 1'b0;
        len   = LEN_W'(1);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: got no out_valid expected out_valid within 2000 cycles");
      sb_q.delete();
      return;
    end
    e = sb_q.pop_front();
    checkOutput("dot_product", 32'(dot_product), 32'(e.dot));
    checkOutput("handshakes", hs, e.hs);
    if (gap == 0) begin
      checkOutput("latency", lat, e.lat);
      checkOutput("in_ready_cycles", ready_cyc, e.hs);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("done_valid_held", 32'(out_valid), 32'd1);
      checkOutput("done_stable", 32'(dot_product), 32'(e.dot));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("idle_after_done", 32'(busy), 32'd0);
    if (poke) begin
      @(negedge clk);
      checkOutput("start_not_queued", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    vec_t v;
    int   seen;
    bit   reached;
    rst = 1'b1; start = 1'b0; len = '0; keep = 1'b0;
    in_valid = 1'b0; a = 16'h0000; b = 16'h0000; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_dot", 32'(dot_product), 32'h0000);

    vecs[0] = mk(1'b0, 3, 16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h3800, 16'h4400, 16'h4C00);
    vecs[1] = mk(1'b1, 1, 16'h4000, 16'h4200, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h4D80);
    vecs[2] = mk(1'b0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    vecs[3] = mk(1'b0, 2, 16'hC000, 16'h3C00, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h4000);
    vecs[4] = mk(1'b0, 2, 16'h3C00, 16'hBC00, 16'h3C00, 16'h3C00, 16'h0000, 16'h0000, 16'h0000);
    vecs[5] = mk(1'b0, 1, 16'h7BFF, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7C00);
    vecs[6] = mk(1'b0, 1, 16'h3E00, 16'h3E00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h4080);
    vecs[7] = mk(1'b1, 1, 16'h3400, 16'h3400, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h40A0);
    vecs[8] = mk(1'b0, 2, 16'h3C00, 16'h3C00, 16'h1000, 16'h3C00, 16'h0000, 16'h0000, 16'h3C00);
    vecs[9] = mk(1'b0, 2, 16'h3C01, 16'h3C00, 16'h1000, 16'h3C00, 16'h0000, 16'h0000, 16'h3C02);

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], 0, 0, 1'b0);

    $display("[TB] backpressure with busy start pulse");
    applyStimulus(vecs[0], 3, 5, 1'b1);

    $display("[TB] length clamp");
    v = mk(1'b0, 20, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4C00);
    v.pa[3] = 16'h3C00;
    v.pb[3] = 16'h3C00;
    applyStimulus(v, 0, 0, 1'b0);

    $display("[TB] reset mid-operation");
    start = 1'b1; keep = 1'b0; len = LEN_W'(4);
    in_valid = 1'b1; a = 16'h3C00; b = 16'h3C00;
    @(negedge clk);
    start = 1'b0; len = '0;
    seen = 0;
    reached = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (in_ready) seen++;
      if (seen == 2) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("two_pairs_reached", 32'(reached), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("mid_acc", 32'(dot_product), 32'h4000);
    rst = 1'b1; start = 1'b1; keep = 1'b1; len = LEN_W'(1);
    @(negedge clk);
    rst = 1'b0; start = 1'b0; keep = 1'b0; len = '0; in_valid = 1'b0;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_dot", 32'(dot_product), 32'h0000);
    @(negedge clk);
    checkOutput("rst_beats_start", 32'(busy), 32'd0);
    sb_q.delete();
    v = mk(1'b1, 1, 16'h3C00, 16'h3C00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3C00);
    applyStimulus(v, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
